// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS control sequencer with memory-ready stall and wait timeout.
// Optional addi support via `MC_ADDI_EN.
module mc_control_fsm #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
`ifdef MC_ADDI_EN
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
`else
    JUMP   = 4'd9
`endif
  } state_t;
  localparam logic [7:0] LIM = 8'(WAIT_LIMIT);
  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       mem_wait;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= FETCH;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  assign mem_wait    = (state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !mem_ready;
  assign wait_d      = mem_wait ? (wait_q == LIM ? wait_q : wait_q + 8'd1) : 8'd0;
  // Fires during the WAIT_LIMIT-th wait cycle; saturation at LIM keeps it to one pulse.
  assign mem_timeout = mem_wait && wait_q == LIM - 8'd1;
  assign state       = state_q;
  always_comb begin
    state_d       = FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          6'b000000:            state_d = EXEC;
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000100:            state_d = BRANCH;
          6'b000010:            state_d = JUMP;
`ifdef MC_ADDI_EN
          6'b001000:            state_d = ADDIEX;
`endif
          default:              illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = opcode == 6'b101011 ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
`ifdef MC_ADDI_EN
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: reg_write = 1'b1;
`endif
      default: state_d = FETCH;
    endcase
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed self-checking bench for the multi-cycle control FSM.
module tb_mc_control_fsm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal, mem_timeout;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  int total = 0;
  int bad = 0;
  int pulses = 0;
  int pulse_at = 0;

  mc_control_fsm #(.WAIT_LIMIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal(illegal), .mem_timeout(mem_timeout),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_mem_read", 8'(mem_read), 8'd1);
    chk("rst_alu_src_b", 8'(alu_src_b), 8'd1);
    chk("rst_ir_write", 8'(ir_write), 8'd1);
    chk("rst_reg_write", 8'(reg_write), 8'd0);
    chk("rst_iord", 8'(iord), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // R-type: 0,1,6,7,0
    tick();
    chk("r_decode", 8'(state), 8'd1);
    chk("r_dec_srcb", 8'(alu_src_b), 8'd3);
    tick();
    chk("r_exec", 8'(state), 8'd6);
    chk("r_exec_aluop", 8'(alu_op), 8'd2);
    chk("r_exec_regwr", 8'(reg_write), 8'd0);
    tick();
    chk("r_aluwb", 8'(state), 8'd7);
    chk("r_aluwb_regwr", 8'(reg_write), 8'd1);
    chk("r_aluwb_regdst", 8'(reg_dst), 8'd1);
    tick();
    chk("r_fetch", 8'(state), 8'd0);
    chk("r_fetch_regwr", 8'(reg_write), 8'd0);
    // FETCH stall: no IR/PC load without mem_ready
    mem_ready = 1'b0;
    #1;
    chk("fstall_irw", 8'(ir_write), 8'd0);
    chk("fstall_pcw", 8'(pc_write), 8'd0);
    tick();
    chk("fstall_state", 8'(state), 8'd0);
    mem_ready = 1'b1;
    // lw with 3 wait cycles in MEMRD: 0,1,2,3,3,3,3,4,0
    opcode = 6'b100011;
    tick();
    chk("lw_decode", 8'(state), 8'd1);
    tick();
    chk("lw_memadr", 8'(state), 8'd2);
    chk("lw_memadr_srcb", 8'(alu_src_b), 8'd2);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lw_memrd_state", 8'(state), 8'd3);
      chk("lw_memrd_rd", 8'(mem_read), 8'd1);
      chk("lw_memrd_iord", 8'(iord), 8'd1);
      tick();
    end
    mem_ready = 1'b1;
    chk("lw_memrd_last", 8'(state), 8'd3);
    chk("lw_memrd_last_rd", 8'(mem_read), 8'd1);
    tick();
    chk("lw_memwb", 8'(state), 8'd4);
    chk("lw_memwb_m2r", 8'(mem_to_reg), 8'd1);
    chk("lw_memwb_regwr", 8'(reg_write), 8'd1);
    chk("lw_memwb_regdst", 8'(reg_dst), 8'd0);
    tick();
    chk("lw_fetch", 8'(state), 8'd0);
    // beq: 0,1,8,0
    opcode = 6'b000100;
    tick();
    tick();
    chk("beq_state", 8'(state), 8'd8);
    chk("beq_pwc", 8'(pc_write_cond), 8'd1);
    chk("beq_pcsrc", 8'(pc_source), 8'd1);
    chk("beq_aluop", 8'(alu_op), 8'd1);
    chk("beq_pcw", 8'(pc_write), 8'd0);
    tick();
    chk("beq_fetch", 8'(state), 8'd0);
    // j: 0,1,9,0
    opcode = 6'b000010;
    tick();
    tick();
    chk("j_state", 8'(state), 8'd9);
    chk("j_pcw", 8'(pc_write), 8'd1);
    chk("j_pcsrc", 8'(pc_source), 8'd2);
    tick();
    chk("j_fetch", 8'(state), 8'd0);
    // sw with 20 wait cycles: single timeout pulse on the 15th
    opcode = 6'b101011;
    tick();
    tick();
    tick();
    chk("sw_memwr", 8'(state), 8'd5);
    mem_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      chk("sw_wait_wr", 8'(mem_write), 8'd1);
      if (mem_timeout) begin
        pulses++;
        pulse_at = i;
      end
      tick();
    end
    chk("sw_pulses", 8'(pulses), 8'd1);
    chk("sw_pulse_at", 8'(pulse_at), 8'd15);
    chk("sw_still_wr", 8'(state), 8'd5);
    mem_ready = 1'b1;
    #1;
    chk("sw_no_to_ready", 8'(mem_timeout), 8'd0);
    tick();
    chk("sw_fetch", 8'(state), 8'd0);
    // addi: legal only with MC_ADDI_EN
    opcode = 6'b001000;
    tick();
    chk("addi_decode", 8'(state), 8'd1);
`ifdef MC_ADDI_EN
    chk("addi_illegal", 8'(illegal), 8'd0);
    tick();
    chk("addi_ex", 8'(state), 8'd10);
    chk("addi_ex_srcb", 8'(alu_src_b), 8'd2);
    tick();
    chk("addi_wb", 8'(state), 8'd11);
    chk("addi_wb_regwr", 8'(reg_write), 8'd1);
    chk("addi_wb_regdst", 8'(reg_dst), 8'd0);
`else
    chk("addi_illegal", 8'(illegal), 8'd1);
`endif
    tick();
    chk("addi_fetch", 8'(state), 8'd0);
    chk("addi_illegal_clr", 8'(illegal), 8'd0);
    // Async reset in MEMRD aborts immediately
    opcode = 6'b100011;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    chk("ar_memrd", 8'(state), 8'd3);
    rst_n = 1'b0;
    #1;
    chk("ar_state", 8'(state), 8'd0);
    chk("ar_regwr", 8'(reg_write), 8'd0);
    chk("ar_memrd_strobe", 8'(mem_read), 8'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar_restart", 8'(state), 8'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
